// File: rtl/cpu54_pkg.sv
// cpu54_pkg: shared definitions for the CPU_54 datapath.
//   DATA_W / ADDR_W : register data and address widths
//   REG_NUM         : number of general registers
//   REG_ZERO/REG_RA : hardwired-zero register and link register ($31)
//   dst_sel_e       : write-destination select encodings (rt / rd / $31)
//   dst_addr()      : resolves the write-back destination from the select
// Optional feature macro used by regfile_wb: REGFILE_BYPASS_EN.
package cpu54_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned REG_NUM = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        DST_RT     = 2'b00,
        DST_RD     = 2'b01,
        DST_RA     = 2'b10,
        DST_RA_ALT = 2'b11
    } dst_sel_e;

    function automatic logic [4:0] dst_addr(input dst_sel_e sel,
                                            input logic [4:0] rt,
                                            input logic [4:0] rd);
        logic [4:0] a;
        a = REG_RA;
        case (sel)
            DST_RT:  a = rt;
            DST_RD:  a = rd;
            default: a = REG_RA;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write (busy) vector.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_we, i_waddr           : write-back retire (clears busy)
//   i_issue_valid/_addr     : producer issue (sets busy; wins over clear)
//   i_raddr1, i_raddr2      : read addresses to look up
//   o_busy1, o_busy2        : busy state for each read address
//   o_any_busy              : OR of all busy bits
// With REGFILE_BYPASS_EN defined, a same-cycle retire to a read address
// reports not-busy unless a new producer to that address issues this cycle.
module regfile_scoreboard
    import cpu54_pkg::*;
#(
    parameter int unsigned ADDR_W = cpu54_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic              i_issue_valid,
    input  logic [ADDR_W-1:0] i_issue_addr,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic              o_busy1,
    output logic              o_busy2,
    output logic              o_any_busy
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_clr;
    logic            w_set;

    assign w_clr = i_we && (i_waddr != '0);
    assign w_set = i_issue_valid && (i_issue_addr != '0);

    // Clear applied before set so a same-address issue supersedes the retire.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) w_busy_nxt[i_waddr] = 1'b0;
        if (w_set) w_busy_nxt[i_issue_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_wm1, w_wm2;
    assign w_wm1 = w_clr && (i_waddr == i_raddr1);
    assign w_wm2 = w_clr && (i_waddr == i_raddr2);
    assign o_busy1 = w_wm1 ? (w_set && (i_issue_addr == i_raddr1)) : r_busy[i_raddr1];
    assign o_busy2 = w_wm2 ? (w_set && (i_issue_addr == i_raddr2)) : r_busy[i_raddr2];
`else
    assign o_busy1 = r_busy[i_raddr1];
    assign o_busy2 = r_busy[i_raddr2];
`endif

    assign o_any_busy = |r_busy;

endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: 32x32 general register file with write-back port, two
// combinational read ports and a pending-write scoreboard.
//   clk, rst              : clock, synchronous active-high reset
//   we, waddr, wdata      : write-back port (writes to $0 discarded)
//   issue_valid/issue_addr: producer issue, marks destination busy
//   raddr1/2, rdata1/2    : combinational read ports ($0 reads 0)
//   busy1/2, any_busy     : scoreboard lookups for decode hazard detection
// Optional macro REGFILE_BYPASS_EN: write-first read bypass of wdata and
// busy state; when undefined, writes are visible one cycle after the edge.
module regfile_wb
    import cpu54_pkg::*;
#(
    parameter int unsigned DATA_W = cpu54_pkg::DATA_W,
    parameter int unsigned ADDR_W = cpu54_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy1,
    output logic              busy2,
    output logic              any_busy
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic              w_wr;

    assign w_wr = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : r_regs[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : r_regs[raddr2];
`ifdef REGFILE_BYPASS_EN
        if (w_wr && (waddr == raddr1)) rdata1 = wdata;
        if (w_wr && (waddr == raddr2)) rdata2 = wdata;
`endif
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_we          (we),
        .i_waddr       (waddr),
        .i_issue_valid (issue_valid),
        .i_issue_addr  (issue_addr),
        .i_raddr1      (raddr1),
        .i_raddr2      (raddr2),
        .o_busy1       (busy1),
        .o_busy2       (busy2),
        .o_any_busy    (any_busy)
    );

endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata1, rdata2;
    logic        busy1, busy2, any_busy;

    int errors = 0;
    int checks = 0;

    // Reference state: what the architectural registers and pending set hold.
    logic [31:0] m_reg [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    regfile_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .busy1(busy1), .busy2(busy2), .any_busy(any_busy)
    );

    function automatic logic [31:0] exp_rdata(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        if (!rst && we && waddr != 0 && waddr == a) return wdata;
`endif
        return (a == 0) ? 32'h0 : m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        if (we && waddr != 0 && waddr == a)
            return (issue_valid && issue_addr != 0 && issue_addr == a);
`endif
        return m_busy[a];
    endfunction

    function automatic logic exp_any();
        logic r = 1'b0;
        for (int i = 0; i < 32; i++) r |= m_busy[i];
        return r;
    endfunction

    task automatic idle();
        we = 0; issue_valid = 0; waddr = '0; issue_addr = '0; wdata = '0;
    endtask

    // Advance one clock; the model commits what the inputs asked for.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
        end else begin
            if (we && waddr != 0) begin m_reg[waddr] = wdata; m_busy[waddr] = 0; end
            if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 12; i++) begin
            we = 1; waddr = 5'($urandom); wdata = $urandom;
            issue_valid = 1; issue_addr = 5'($urandom);
            tick();
        end
        idle(); rst = 1; tick(); rst = 0; #1;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i); #1;
            checks++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_rdata addr=%0d got=%h/%h exp=0", i, rdata1, rdata2);
            end
            checks++;
            if (busy1 !== 1'b0 || busy2 !== 1'b0 || any_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy addr=%0d got=%b%b%b exp=000", i, busy1, busy2, any_busy);
            end
        end
    endtask

    task automatic test_basic_write();
        logic [31:0] e;
        we = 1; waddr = 5'd8; wdata = 32'hDEADBEEF; raddr1 = 5'd8; #1;
`ifdef REGFILE_BYPASS_EN
        e = 32'hDEADBEEF;
`else
        e = 32'h0;
`endif
        checks++;
        if (rdata1 !== e) begin errors++; $display("FAIL basic_same_cycle got=%h exp=%h", rdata1, e); end
        tick(); idle(); #1;
        checks++;
        if (rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_next_cycle got=%h exp=deadbeef", rdata1); end
        raddr2 = 5'd8; #1;
        checks++;
        if (rdata2 !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_port2 got=%h exp=deadbeef", rdata2); end
    endtask

    task automatic test_zero_reg();
        we = 1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        issue_valid = 1; issue_addr = 5'd0; raddr1 = 5'd0; #1;
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("FAIL zero_same_cycle got=%h exp=0", rdata1); end
        tick(); idle(); #1;
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("FAIL zero_rdata got=%h exp=0", rdata1); end
        checks++;
        if (busy1 !== 1'b0 || any_busy !== exp_any()) begin
            errors++; $display("FAIL zero_busy got=%b/%b exp=0/%b", busy1, any_busy, exp_any());
        end
    endtask

    task automatic test_scoreboard_lifecycle();
        issue_valid = 1; issue_addr = 5'd31; raddr2 = 5'd31;
        tick(); idle(); #1;
        checks++;
        if (busy2 !== 1'b1) begin errors++; $display("FAIL life_set got=%b exp=1", busy2); end
        we = 1; waddr = 5'd31; wdata = 32'h00400010; #1;
        checks++;
        if (busy2 !== exp_busy(5'd31) || rdata2 !== exp_rdata(5'd31)) begin
            errors++;
            $display("FAIL life_retire_cycle got=%b/%h exp=%b/%h", busy2, rdata2, exp_busy(5'd31), exp_rdata(5'd31));
        end
        tick(); idle(); #1;
        checks++;
        if (busy2 !== 1'b0 || rdata2 !== 32'h00400010) begin
            errors++; $display("FAIL life_clear got=%b/%h exp=0/00400010", busy2, rdata2);
        end
    endtask

    task automatic test_set_clear_same();
        logic [31:0] d;
        d = $urandom;
        issue_valid = 1; issue_addr = 5'd9; raddr1 = 5'd9;
        tick();
        we = 1; waddr = 5'd9; wdata = d; #1;
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL setclr_same_cycle got=%b exp=1", busy1); end
        tick(); idle(); #1;
        checks++;
        if (busy1 !== 1'b1 || rdata1 !== d) begin
            errors++; $display("FAIL setclr_result got=%b/%h exp=1/%h", busy1, rdata1, d);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d;
        d = $urandom;
        issue_valid = 1; issue_addr = 5'd3; tick();
        issue_addr = 5'd12; tick(); idle(); #1;
        checks++;
        if (any_busy !== 1'b1) begin errors++; $display("FAIL mid_pending got=%b exp=1", any_busy); end
        rst = 1; tick(); rst = 0; #1;
        checks++;
        if (any_busy !== 1'b0) begin errors++; $display("FAIL mid_after_reset got=%b exp=0", any_busy); end
        we = 1; waddr = 5'd3; wdata = d; raddr1 = 5'd3; tick(); idle(); #1;
        checks++;
        if (rdata1 !== d || any_busy !== 1'b0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL mid_write got=%h/%b exp=%h/0", rdata1, any_busy, d);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            we = $urandom_range(0, 1);
            // Bias addresses toward a small set so collisions happen often.
            waddr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wdata = $urandom;
            issue_valid = $urandom_range(0, 1);
            issue_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            raddr1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom);
            #1;
            if (!rst) begin
                checks++;
                if (rdata1 !== exp_rdata(raddr1) || rdata2 !== exp_rdata(raddr2)) begin
                    errors++;
                    $display("FAIL rand_rdata n=%0d a=%0d/%0d got=%h/%h exp=%h/%h", n, raddr1, raddr2,
                             rdata1, rdata2, exp_rdata(raddr1), exp_rdata(raddr2));
                end
                checks++;
                if (busy1 !== exp_busy(raddr1) || busy2 !== exp_busy(raddr2) || any_busy !== exp_any()) begin
                    errors++;
                    $display("FAIL rand_busy n=%0d got=%b%b%b exp=%b%b%b", n, busy1, busy2, any_busy,
                             exp_busy(raddr1), exp_busy(raddr2), exp_any());
                end
            end
            tick();
        end
        rst = 0; idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
        @(negedge clk);
        tick(); tick();
        rst = 0;
        test_reset();
        test_basic_write();
        test_zero_reg();
        test_scoreboard_lifecycle();
        test_set_clear_same();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
